// File: rtl/pipeline_skid_buffer_pkg.sv
// Shared definitions for the pipeline skid buffer: state encoding,
// default payload width and the state-to-occupancy mapping.
package pipeline_skid_buffer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Number of items held in a given state.
  function automatic logic [1:0] state_count(input state_t s);
    logic [1:0] c;
    case (s)
      EMPTY:   c = 2'd0;
      BUSY:    c = 2'd1;
      FULL:    c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/flipFlop.sv
// Plain N-bit register with synchronous active-high reset to zero.
// Load enables are expressed by the caller through the d input.
module flipFlop #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Capture d every edge; reset clears to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_skid_buffer.sv
// Two-entry skid buffer. The main register drives out_data; the skid
// register catches the one item accepted while the downstream stalls.
// All outputs come straight from registers, so neither in_ready nor
// out_valid depends combinationally on out_ready or in_valid.
//
// Handshake: a transfer happens on an edge where valid and ready are both
// high (accept = in_valid && in_ready, pop = out_valid && out_ready);
// valid must not wait on ready, and data is only meaningful with valid.
module pipeline_skid_buffer
  import pipeline_skid_buffer_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count,
  output logic [1:0]   dbg_state
);

  state_t       r_state;
  state_t       w_state_next;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [1:0]   r_count;
  logic         w_accept;
  logic         w_pop;
  logic [N-1:0] w_main_d;
  logic [N-1:0] w_main_q;
  logic [N-1:0] w_skid_d;
  logic [N-1:0] w_skid_q;

  assign w_accept = in_valid && r_in_ready;
  assign w_pop    = r_out_valid && out_ready;

  // Next state and register loads; flush overrides everything but reset
  // and leaves the data registers holding their last contents.
  always_comb begin
    w_state_next = r_state;
    w_main_d     = w_main_q;
    w_skid_d     = w_skid_q;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_main_d     = in_data;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (w_accept && w_pop) begin
          w_main_d = in_data;
        end else if (w_accept) begin
          w_skid_d     = in_data;
          w_state_next = FULL;
        end else if (w_pop) begin
          w_state_next = EMPTY;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_main_d     = w_skid_q;
          w_state_next = BUSY;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
    if (flush) begin
      w_state_next = EMPTY;
      w_main_d     = w_main_q;
      w_skid_d     = w_skid_q;
    end
  end

  // State register plus registered copies of the status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != FULL);
      r_out_valid <= (w_state_next != EMPTY);
      r_count     <= state_count(w_state_next);
    end
  end

  flipFlop #(.N(N)) u_main (
    .clk   (clk),
    .reset (reset),
    .d     (w_main_d),
    .q     (w_main_q)
  );

  flipFlop #(.N(N)) u_skid (
    .clk   (clk),
    .reset (reset),
    .d     (w_skid_d),
    .q     (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Bench for pipeline_skid_buffer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue model.
module tb_pipeline_skid_buffer;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;
  logic [1:0]   dbg_state;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         f;
    logic         e_ov;
    logic         e_ir;
    logic [1:0]   e_cnt;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t vecs[12];

  pipeline_skid_buffer #(.N(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic check_status(input string tag, input logic ov, input logic ir, input logic [1:0] c);
    check({tag, ".out_valid"}, W'(out_valid), W'(ov));
    check({tag, ".in_ready"},  W'(in_ready),  W'(ir));
    check({tag, ".count"},     W'(count),     W'(c));
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Queue model of one edge: occupancy before the edge decides ready/valid.
  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    int  sz;
    logic acc;
    logic pop;
    sz  = exp_q.size();
    acc = v && (sz < 2);
    pop = (sz > 0) && r;
    if (f) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
    end
  endtask

  initial begin
    logic [W-1:0] prev_od;
    logic         prev_stall;
    logic         rv;
    logic         rr;
    logic         rf;
    logic [W-1:0] rd;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset state
    do_reset();
    check_status("reset", 1'b0, 1'b1, 2'd0);
    check("reset.out_data", out_data, '0);

    // Directed vector table, starting from EMPTY
    vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h1,        1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1};
    vecs[3]  = '{1'b1, 32'h2,        1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h1};
    vecs[4]  = '{1'b1, 32'h3,        1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h1};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h2};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h2};
    vecs[7]  = '{1'b1, 32'hA,        1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA};
    vecs[8]  = '{1'b1, 32'hB,        1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hB};
    vecs[9]  = '{1'b1, 32'hC,        1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hB};
    vecs[10] = '{1'b1, 32'hD,        1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'hB};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'hB};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f);
      step();
      check_status($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_cnt);
      check($sformatf("vec%0d.out_data", i), out_data, vecs[i].e_od);
    end

    // Streaming: one item in and one out every cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      step();
      check($sformatf("stream%0d.out_data", i), out_data, W'(i));
      check_status($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check_status("stream_drain", 1'b0, 1'b1, 2'd0);

    // Reset while FULL with flush, pop and push all pending
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    step();
    check_status("prefull", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 32'h33, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    check_status("rst_full", 1'b0, 1'b1, 2'd0);
    check("rst_full.out_data", out_data, '0);
    reset = 1'b0;
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    step();
    check_status("first_after_rst", 1'b1, 1'b1, 2'd1);
    check("first_after_rst.out_data", out_data, 32'h44);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check_status("drain2", 1'b0, 1'b1, 2'd0);

    // Randomized traffic against the queue model
    exp_q.delete();
    prev_od    = out_data;
    prev_stall = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      rv = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < 55);
      rf = ($urandom_range(0, 63) == 0);
      rd = $urandom;
      drive(rv, rd, rr, rf);
      prev_stall = out_valid && !rr && !rf;
      prev_od    = out_data;
      model_edge(rv, rd, rr, rf);
      step();
      check_status($sformatf("rand%0d", c), exp_q.size() > 0, exp_q.size() < 2, 2'(exp_q.size()));
      if (exp_q.size() > 0) begin
        check($sformatf("rand%0d.out_data", c), out_data, exp_q[0]);
      end
      if (prev_stall) begin
        check($sformatf("rand%0d.stall_hold", c), out_data, prev_od);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_buffer.md
PIPELINE_SKID_BUFFER -- requirements
Module: pipeline_skid_buffer

Interface
REQ-001 Parameter: N, default 32, data width in bits (N >= 1).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  synchronous discard of all held data.
REQ-005 in_valid  input  1  upstream presents in_data.
REQ-006 in_ready  output  1  buffer can accept this cycle.
REQ-007 in_data  input  N  upstream payload.
REQ-008 out_valid  output  1  out_data holds a valid item.
REQ-009 out_ready  input  1  downstream consumes this cycle.
REQ-010 out_data  output  N  head item.
REQ-011 count  output  2  items held (0..2).

Function
REQ-012 Accept = in_valid && in_ready; pop = out_valid && out_ready; both evaluated at the same rising edge.
REQ-013 Storage: main register (drives out_data) plus one skid register; states EMPTY (0 items), BUSY (main only), FULL (main and skid).
REQ-014 in_ready, out_valid, out_data and count are driven directly from registers, with no combinational path from any input to any output.
REQ-015 in_ready = 1 in EMPTY and BUSY; 0 in FULL.
REQ-016 out_valid = 1 in BUSY and FULL; 0 in EMPTY.
REQ-017 EMPTY: accept -> main <= in_data, go BUSY; no accept -> stay.
REQ-018 BUSY: accept && pop -> main <= in_data, stay BUSY; accept && !pop -> skid <= in_data, go FULL; !accept && pop -> go EMPTY; neither -> stay.
REQ-019 FULL: pop -> main <= skid, go BUSY; no pop -> stay; in_valid ignored.
REQ-020 Latency: item accepted at edge k appears on out_data with out_valid=1 after edge k if the buffer was EMPTY, or BUSY with a simultaneous pop.
REQ-021 Ordering is strictly FIFO; no item is dropped or duplicated except by flush or reset.
REQ-022 While out_valid=1 and out_ready=0, out_data holds stable.
REQ-023 flush=1 at an edge: go EMPTY and drop any simultaneous accept; outputs after the edge are out_valid=0, in_ready=1, count=0.
REQ-024 reset takes priority over flush and over all handshake activity.
REQ-025 count = 0, 1 or 2 in EMPTY, BUSY or FULL respectively; no other value occurs.
REQ-026 out_data holds its last value when out_valid=0; consumers do not sample it in that state.

Reset
REQ-027 reset=1 at an edge: state EMPTY, out_valid=0, in_ready=1, count=0, main and skid registers = 0 (out_data = {N{1'b0}}).
REQ-028 Reset mid-operation, including in FULL with a handshake pending, discards both items with no pop reported.
REQ-029 The first accept is possible at the first edge after reset deasserts.

Structure
REQ-030 The shared package holds state encodings EMPTY=2'd0, BUSY=2'd1, FULL=2'd2 and the default width constant 32.
REQ-031 Main and skid registers each instantiate the existing N-bit flipFlop register as the single sub-module, with load enable gated through its d input.
REQ-032 The state register and control logic are local to pipeline_skid_buffer.

Verification
REQ-033 Reset, then in_valid=1 with in_data=32'hDEADBEEF and out_ready=1 -> after one edge out_valid=1, out_data=DEADBEEF, count=1.
REQ-034 out_ready=0, push A=32'h1 then B=32'h2 -> count=2, in_ready=0, out_data=1; push C=32'h3 while FULL -> ignored; raise out_ready -> pops in order 1, then 2, with C never appearing.
REQ-035 Streaming with in_valid=1 and out_ready=1 every cycle on values 0..15 -> out_data = 0..15 on consecutive cycles, count stays 1, in_ready stays 1.
REQ-036 In FULL, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; the flushed items and the simultaneous input never appear.
REQ-037 In FULL, assert reset together with flush and out_ready=1 -> out_data=0, out_valid=0, in_ready=1, count=0.
REQ-038 Random valid/ready stimulus over 1000 cycles against a scoreboard queue -> output order matches input order, no loss, and out_data stable while stalled.
